// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem offload path: predecoder handshake,
// q/p channel bundles and the initiator FSM states.
package fpu_ss_pkg;

  localparam int unsigned NUM_RS = 3;

  typedef struct packed {
    logic [31:0] q_instr_data;
  } acc_prd_req_t;

  typedef struct packed {
    logic              p_accept;
    logic [1:0]        p_writeback;
    logic              p_is_mem_op;
    logic [NUM_RS-1:0] p_use_rs;
  } acc_prd_rsp_t;

  typedef enum logic [1:0] {IDLE, PRED, ISSUE} initiator_state_e;

  typedef struct packed {
    logic [31:0]             op;
    logic [NUM_RS-1:0][31:0] arg;
    logic [4:0]              id;
  } acc_req_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
  } acc_rsp_t;

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// Pending-writeback mask over the 32 integer registers plus an outstanding
// counter; a set and clear of the same register in one cycle leaves it set.
module fpu_ss_scoreboard #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_set,
  input  logic [4:0] i_set_rd,
  input  logic       i_clr,
  input  logic [4:0] i_clr_rd,
  input  logic [4:0] i_query_rd,
  output logic       o_pending,
  output logic       o_full,
  output logic       o_busy
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [31:0]     r_mask, w_mask_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            w_set, w_clr;

  // Only responses for tracked registers retire a slot, so the count never underflows.
  always_comb begin
    w_set      = i_set & (i_set_rd != 5'd0);
    w_clr      = i_clr & r_mask[i_clr_rd];
    w_mask_nxt = r_mask;
    if (w_clr) w_mask_nxt[i_clr_rd] = 1'b0;
    if (w_set) w_mask_nxt[i_set_rd] = 1'b1;
    w_cnt_nxt  = r_cnt;
    if (w_set && !w_clr)      w_cnt_nxt = r_cnt + CntW'(1);
    else if (!w_set && w_clr) w_cnt_nxt = r_cnt - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mask <= '0;
      r_cnt  <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_pending = r_mask[i_query_rd];
  assign o_full    = (r_cnt == CntW'(MaxOutstanding));
  assign o_busy    = |r_cnt;

endmodule

// File: rtl/fpu_ss_offload_initiator.sv
// Core-side offload initiator: predecode, operand gather, request issue,
// and writeback return with register-level hazard tracking.
module fpu_ss_offload_initiator
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NumRs          = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [31:0]            instr_data_i,
  input  logic [NumRs-1:0][31:0] rs_i,
  input  logic [NumRs-1:0]       rs_valid_i,
  output acc_prd_req_t           prd_req_o,
  input  acc_prd_rsp_t           prd_rsp_i,
  output logic                   acc_qvalid_o,
  input  logic                   acc_qready_i,
  output logic [31:0]            acc_qdata_op_o,
  output logic [NumRs-1:0][31:0] acc_qdata_arg_o,
  output logic [4:0]             acc_qid_o,
  input  logic                   acc_pvalid_i,
  output logic                   acc_pready_o,
  input  logic [4:0]             acc_pid_i,
  input  logic [31:0]            acc_pdata_i,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [31:0]            wb_data_o,
  output logic                   illegal_o,
  output logic                   busy_o
);
  initiator_state_e r_state, w_state_nxt;
  acc_req_t         r_req;
  acc_prd_rsp_t     r_prd;
  acc_rsp_t         r_wb;
  logic             r_wb_valid, r_illegal, r_pready;
  logic             w_take, w_latch, w_illegal_nxt, w_rs_ok, w_hazard;
  logic             w_q_hs, w_p_hs, w_pending, w_full, w_sb_busy;
  logic [4:0]       w_rd;
  logic             w_unused;

  assign w_rd   = r_req.id;
  assign w_take = instr_valid_i & instr_ready_o;
  assign w_q_hs = acc_qvalid_o & acc_qready_i;
  assign w_p_hs = acc_pvalid_i & r_pready;

  always_comb begin
    w_rs_ok = 1'b1;
    for (int k = 0; k < NumRs; k++)
      if (prd_rsp_i.p_use_rs[k] && !rs_valid_i[k]) w_rs_ok = 1'b0;
  end

  assign w_hazard = ~w_rs_ok | w_full |
                    (prd_rsp_i.p_writeback[0] & (w_rd != 5'd0) & w_pending);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    instr_ready_o = 1'b0;
    acc_qvalid_o  = 1'b0;
    w_latch       = 1'b0;
    w_illegal_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) w_state_nxt = PRED;
      end
      PRED: begin
        if (!prd_rsp_i.p_accept) begin
          w_illegal_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else if (!w_hazard) begin
          w_latch     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        acc_qvalid_o = 1'b1;
        if (acc_qready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req      <= '0;
      r_prd      <= '0;
      r_wb       <= '0;
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_pready   <= 1'b0;
    end else begin
      r_pready   <= 1'b1;
      r_illegal  <= w_illegal_nxt;
      r_wb_valid <= w_p_hs;
      if (w_p_hs) r_wb <= '{id: acc_pid_i, data: acc_pdata_i};
      if (w_take) begin
        r_req.op <= instr_data_i;
        r_req.id <= instr_data_i[11:7];
      end
      // Unused operand slots go out as zero rather than stale register values.
      if (w_latch) begin
        r_prd <= prd_rsp_i;
        for (int k = 0; k < NumRs; k++)
          r_req.arg[k] <= prd_rsp_i.p_use_rs[k] ? rs_i[k] : 32'd0;
      end
    end
  end

  fpu_ss_scoreboard #(.MaxOutstanding(MaxOutstanding)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_set      (w_q_hs & r_prd.p_writeback[0]),
    .i_set_rd   (w_rd),
    .i_clr      (w_p_hs),
    .i_clr_rd   (acc_pid_i),
    .i_query_rd (w_rd),
    .o_pending  (w_pending),
    .o_full     (w_full),
    .o_busy     (w_sb_busy)
  );

  assign prd_req_o.q_instr_data = r_req.op;
  assign acc_qdata_op_o  = r_req.op;
  assign acc_qdata_arg_o = r_req.arg;
  assign acc_qid_o       = r_req.id;
  assign acc_pready_o    = r_pready;
  assign wb_valid_o      = r_wb_valid;
  assign wb_rd_o         = r_wb.id;
  assign wb_data_o       = r_wb.data;
  assign illegal_o       = r_illegal;
  assign busy_o          = (r_state != IDLE) | w_sb_busy;

  // Mem-op flag and upper writeback bit are carried for downstream use only.
  assign w_unused = ^{r_prd.p_accept, r_prd.p_writeback[1], r_prd.p_is_mem_op, r_prd.p_use_rs};

endmodule

// File: tb/tb_fpu_ss_offload_initiator.sv
// Directed protocol scenarios plus a random instruction/response mix, all
// checked against a register-set / counter model of outstanding writebacks.
module tb_fpu_ss_offload_initiator;
  import fpu_ss_pkg::*;

  localparam int MAX = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              instr_valid_i, instr_ready_o;
  logic [31:0]       instr_data_i;
  logic [2:0][31:0]  rs_i;
  logic [2:0]        rs_valid_i;
  acc_prd_req_t      prd_req_o;
  acc_prd_rsp_t      prd_rsp_i;
  logic              acc_qvalid_o, acc_qready_i;
  logic [31:0]       acc_qdata_op_o;
  logic [2:0][31:0]  acc_qdata_arg_o;
  logic [4:0]        acc_qid_o;
  logic              acc_pvalid_i, acc_pready_o;
  logic [4:0]        acc_pid_i;
  logic [31:0]       acc_pdata_i;
  logic              wb_valid_o;
  logic [4:0]        wb_rd_o;
  logic [31:0]       wb_data_o;
  logic              illegal_o, busy_o;

  always #5 clk_i = ~clk_i;

  fpu_ss_offload_initiator #(.NumRs(3), .MaxOutstanding(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_data_i(instr_data_i),
    .rs_i(rs_i), .rs_valid_i(rs_valid_i),
    .prd_req_o(prd_req_o), .prd_rsp_i(prd_rsp_i),
    .acc_qvalid_o(acc_qvalid_o), .acc_qready_i(acc_qready_i), .acc_qdata_op_o(acc_qdata_op_o),
    .acc_qdata_arg_o(acc_qdata_arg_o), .acc_qid_o(acc_qid_o),
    .acc_pvalid_i(acc_pvalid_i), .acc_pready_o(acc_pready_o), .acc_pid_i(acc_pid_i),
    .acc_pdata_i(acc_pdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: set of registers awaiting a result, and how many.
  bit               mdl_pend [32];
  int               mdl_cnt;
  bit               prev_p;
  logic [4:0]       prev_pid;
  logic [31:0]      prev_pdata;
  int               iss_cnt = 0, ill_cnt = 0;
  logic [31:0]      exp_op;
  logic [2:0][31:0] exp_args;
  bit               exp_wbf;
  bit               auto_en = 1'b0;
  int               cand_q[$];

  task automatic mdl_clear();
    foreach (mdl_pend[i]) mdl_pend[i] = 1'b0;
    mdl_cnt = 0;
    prev_p  = 1'b0;
  endtask

  // Values seen at the falling edge are what the next rising edge commits.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("wb_valid", wb_valid_o, prev_p);
      if (prev_p) begin
        chk("wb_rd", wb_rd_o, prev_pid);
        chk("wb_data", wb_data_o, prev_pdata);
      end
      if (instr_ready_o) chk("busy_idle", busy_o, mdl_cnt != 0);
      if (illegal_o) ill_cnt++;
      if (acc_qvalid_o && acc_qready_i) begin
        iss_cnt++;
        chk("q_op", acc_qdata_op_o, exp_op);
        chk("q_id", acc_qid_o, exp_op[11:7]);
        for (int k = 0; k < 3; k++) chk("q_arg", acc_qdata_arg_o[k], exp_args[k]);
        if (exp_wbf && exp_op[11:7] != 5'd0) begin
          chk("raw_issue", mdl_pend[exp_op[11:7]], 1'b0);
          chk("full_issue", mdl_cnt < MAX, 1'b1);
        end
      end
      prev_p = acc_pvalid_i;
      prev_pid = acc_pid_i;
      prev_pdata = acc_pdata_i;
      if (acc_pvalid_i) begin
        chk("pready", acc_pready_o, 1'b1);
        if (mdl_pend[acc_pid_i]) begin
          mdl_pend[acc_pid_i] = 1'b0;
          mdl_cnt--;
        end
      end
      if (acc_qvalid_o && acc_qready_i && exp_wbf && exp_op[11:7] != 5'd0) begin
        mdl_pend[exp_op[11:7]] = 1'b1;
        mdl_cnt++;
      end
    end
  end

  // Random environment: backpressure, operand hazards and responses.
  always @(posedge clk_i) begin
    #1;
    if (auto_en) begin
      acc_qready_i = ($urandom_range(0, 1) == 1);
      rs_valid_i   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      acc_pvalid_i = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        cand_q.delete();
        for (int i = 1; i < 32; i++) if (mdl_pend[i]) cand_q.push_back(i);
        acc_pvalid_i = 1'b1;
        acc_pdata_i  = $urandom;
        if (cand_q.size() > 0 && $urandom_range(0, 9) != 0)
          acc_pid_i = 5'(cand_q[$urandom_range(0, cand_q.size() - 1)]);
        else
          acc_pid_i = 5'($urandom_range(0, 31));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [31:0] ins, input bit acc, input bit wbf,
                       input logic [2:0] use_rs, input logic [2:0][31:0] vals);
    int w = 0;
    rs_i    = vals;
    exp_op  = ins;
    exp_wbf = wbf;
    for (int k = 0; k < 3; k++) exp_args[k] = use_rs[k] ? vals[k] : 32'd0;
    prd_rsp_i.p_accept    = acc;
    prd_rsp_i.p_writeback = {1'b0, wbf};
    prd_rsp_i.p_is_mem_op = 1'b0;
    prd_rsp_i.p_use_rs    = use_rs;
    instr_data_i  = ins;
    instr_valid_i = 1'b1;
    while (!instr_ready_o && w < 300) begin
      tick();
      w++;
    end
    if (!instr_ready_o) chk("ready_timeout", 1'b0, 1'b1);
    tick();
    instr_valid_i = 1'b0;
    instr_data_i  = $urandom;
  endtask

  task automatic wait_done(input int bound, output int lat, output bit issued, output bit rejected);
    int i0 = iss_cnt, l0 = ill_cnt;
    lat = 0;
    while (iss_cnt == i0 && ill_cnt == l0 && lat < bound) begin
      tick();
      lat++;
    end
    issued   = (iss_cnt != i0);
    rejected = (ill_cnt != l0);
  endtask

  task automatic send(input string tag, input logic [4:0] rd, input logic [2:0] use_rs,
                      input int exp_lat);
    logic [2:0][31:0] v;
    int lat;
    bit iss, rej;
    for (int k = 0; k < 3; k++) v[k] = $urandom;
    start({20'hC0000, rd, 7'h53}, 1'b1, 1'b1, use_rs, v);
    wait_done(50, lat, iss, rej);
    chk({tag, "_issued"}, iss, 1'b1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic resp(input logic [4:0] pid, input logic [31:0] data);
    acc_pvalid_i = 1'b1;
    acc_pid_i    = pid;
    acc_pdata_i  = data;
    tick();
    acc_pvalid_i = 1'b0;
  endtask

  initial begin
    logic [2:0][31:0] v;
    int lat, i0;
    bit iss, rej;

    rst_i = 1'b1;
    instr_valid_i = 1'b0; instr_data_i = '0; rs_i = '0; rs_valid_i = 3'b111;
    prd_rsp_i = '0; acc_qready_i = 1'b1; acc_pvalid_i = 1'b0; acc_pid_i = '0; acc_pdata_i = '0;
    mdl_clear();
    tick(); tick();
    chk("rst_ready", instr_ready_o, 1'b1);
    chk("rst_qvalid", acc_qvalid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wb", wb_valid_o, 1'b0);
    chk("rst_illegal", illegal_o, 1'b0);
    chk("rst_pready", acc_pready_o, 1'b0);
    rst_i = 1'b0;
    tick();
    chk("pready_on", acc_pready_o, 1'b1);

    // Reject path
    i0 = iss_cnt;
    v = '0;
    start(32'h0000_0013, 1'b0, 1'b0, 3'b000, v);
    chk("rej_prd_req", prd_req_o.q_instr_data, 32'h0000_0013);
    chk("rej_ready_pred", instr_ready_o, 1'b0);
    chk("rej_ill_early", illegal_o, 1'b0);
    tick();
    chk("rej_ill", illegal_o, 1'b1);
    chk("rej_ready_back", instr_ready_o, 1'b1);
    chk("rej_qvalid", acc_qvalid_o, 1'b0);
    tick();
    chk("rej_ill_pulse", illegal_o, 1'b0);
    chk("rej_no_issue", iss_cnt, i0);

    // FCVT.W.S to x5 and its writeback
    v[0] = 32'h3F80_0000; v[1] = 32'h1111_1111; v[2] = 32'h2222_2222;
    start(32'hC000_02D3, 1'b1, 1'b1, 3'b001, v);
    wait_done(50, lat, iss, rej);
    chk("fcvt_issued", iss, 1'b1);
    chk("fcvt_lat", lat, 2);
    chk("fcvt_busy", busy_o, 1'b1);
    resp(5'd5, 32'd1);
    chk("fcvt_wb_valid", wb_valid_o, 1'b1);
    chk("fcvt_wb_rd", wb_rd_o, 5'd5);
    chk("fcvt_wb_data", wb_data_o, 32'd1);
    tick();
    chk("fcvt_idle", busy_o, 1'b0);

    // RAW on x5 holds; independent x6 goes straight through
    send("raw_a", 5'd5, 3'b001, 2);
    i0 = iss_cnt;
    for (int k = 0; k < 3; k++) v[k] = $urandom;
    start(32'hC000_02D3, 1'b1, 1'b1, 3'b000, v);
    repeat (5) tick();
    chk("raw_hold", iss_cnt, i0);
    chk("raw_hold_q", acc_qvalid_o, 1'b0);
    resp(5'd5, 32'hAAAA_0005);
    tick();
    chk("raw_release_q", acc_qvalid_o, 1'b1);
    wait_done(5, lat, iss, rej);
    chk("raw_release", iss, 1'b1);
    send("raw_x6", 5'd6, 3'b010, 2);
    resp(5'd5, 32'h5); resp(5'd6, 32'h6);

    // Backpressure: request frozen while qready is low
    acc_qready_i = 1'b0;
    for (int k = 0; k < 3; k++) v[k] = $urandom;
    start({20'hC0000, 5'd9, 7'h53}, 1'b1, 1'b1, 3'b111, v);
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_qvalid", acc_qvalid_o, 1'b1);
      chk("bp_op", acc_qdata_op_o, exp_op);
      chk("bp_id", acc_qid_o, 5'd9);
      chk("bp_arg1", acc_qdata_arg_o[1], v[1]);
      tick();
    end
    acc_qready_i = 1'b1;
    wait_done(5, lat, iss, rej);
    chk("bp_issued", iss, 1'b1);
    resp(5'd9, 32'h9);

    // Full: fifth writer waits for a slot
    for (int r = 10; r < 14; r++) send("fill", 5'(r), 3'b001, 2);
    i0 = iss_cnt;
    for (int k = 0; k < 3; k++) v[k] = $urandom;
    start({20'hC0000, 5'd14, 7'h53}, 1'b1, 1'b1, 3'b001, v);
    repeat (6) tick();
    chk("full_hold", iss_cnt, i0);
    resp(5'd10, 32'h10);
    tick();
    chk("full_release_q", acc_qvalid_o, 1'b1);
    wait_done(5, lat, iss, rej);
    chk("full_release", iss, 1'b1);
    for (int r = 11; r < 15; r++) resp(5'(r), 32'(r));

    // Issue to x7 in the same cycle as a response for x7: x7 stays pending
    acc_qready_i = 1'b0;
    for (int k = 0; k < 3; k++) v[k] = $urandom;
    start({20'hC0000, 5'd7, 7'h53}, 1'b1, 1'b1, 3'b001, v);
    tick();
    acc_qready_i = 1'b1;
    resp(5'd7, 32'h7777);
    tick();
    chk("sim_busy", busy_o, 1'b1);
    i0 = iss_cnt;
    start({20'hC0000, 5'd7, 7'h53}, 1'b1, 1'b1, 3'b000, v);
    repeat (4) tick();
    chk("sim_x7_hold", iss_cnt, i0);
    resp(5'd7, 32'h7);
    wait_done(5, lat, iss, rej);
    chk("sim_x7_issue", iss, 1'b1);
    resp(5'd7, 32'h77);

    // Issue to x21 while x20 retires: outstanding count stays at one
    send("sim_x20", 5'd20, 3'b001, 2);
    acc_qready_i = 1'b0;
    start({20'hC0000, 5'd21, 7'h53}, 1'b1, 1'b1, 3'b001, v);
    tick();
    acc_qready_i = 1'b1;
    resp(5'd20, 32'h20);
    tick();
    resp(5'd21, 32'h21);
    tick();
    chk("sim_cnt_drain", busy_o, 1'b0);

    // Operand hazard on rs2, unused slots forced to zero
    rs_valid_i = 3'b101;
    v[0] = 32'hDEAD_0000; v[1] = 32'hBEEF_0001; v[2] = 32'hCAFE_0002;
    i0 = iss_cnt;
    start({20'hC0000, 5'd8, 7'h53}, 1'b1, 1'b1, 3'b010, v);
    repeat (4) tick();
    chk("rs_hold", iss_cnt, i0);
    chk("rs_hold_q", acc_qvalid_o, 1'b0);
    rs_valid_i = 3'b111;
    wait_done(5, lat, iss, rej);
    chk("rs_release", iss, 1'b1);
    resp(5'd8, 32'h8);

    // Async reset in the middle of an issue
    send("rst_x3", 5'd3, 3'b001, 2);
    acc_qready_i = 1'b0;
    start({20'hC0000, 5'd4, 7'h53}, 1'b1, 1'b1, 3'b001, v);
    tick();
    chk("rst_mid_q", acc_qvalid_o, 1'b1);
    #2 rst_i = 1'b1;
    mdl_clear();
    #1;
    chk("rst_async_q", acc_qvalid_o, 1'b0);
    chk("rst_async_busy", busy_o, 1'b0);
    tick();
    rst_i = 1'b0;
    acc_qready_i = 1'b1;
    tick();
    chk("rst_after_busy", busy_o, 1'b0);
    send("rst_x3_again", 5'd3, 3'b001, 2);
    resp(5'd3, 32'h3);

    // Random mix
    auto_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rd;
      bit acc, wbf;
      logic [2:0] use_rs;
      rd     = 5'($urandom_range(0, 7));
      acc    = ($urandom_range(0, 4) != 0);
      wbf    = ($urandom_range(0, 3) != 0);
      use_rs = 3'($urandom);
      for (int k = 0; k < 3; k++) v[k] = $urandom;
      start({12'($urandom), 8'($urandom), rd, 7'h53}, acc, wbf, use_rs, v);
      wait_done(300, lat, iss, rej);
      chk("rand_issue", iss, acc);
      chk("rand_reject", rej, !acc);
    end
    auto_en = 1'b0;
    tick();
    acc_qready_i = 1'b1;
    acc_pvalid_i = 1'b0;
    rs_valid_i   = 3'b111;
    tick();
    for (int i = 1; i < 32; i++) if (mdl_pend[i]) resp(5'(i), $urandom);
    tick(); tick();
    chk("drain_busy", busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
